// File: rtl/refclk_gate_div.sv
// Behavioural GT refclk input buffer: synchronised glitch-free clock gate,
// even divider on the auxiliary output, and a lock indicator.
module refclk_gate_div #(
  parameter bit          REFCLK_EN_TX_PATH  = 1'b0,
  parameter bit [1:0]    REFCLK_HROW_CK_SEL = 2'b00,
  parameter int unsigned DIV_RATIO          = 4,
  parameter int unsigned CE_SYNC_STAGES     = 2,
  parameter int unsigned LOCK_CNT           = 16
) (
  input  logic I,
  input  logic RSTB,
  input  logic IB,
  input  logic CEB,
  output logic O,
  output logic ODIV2,
  output logic LOCKED
);

  localparam int unsigned HALF      = DIV_RATIO / 2;
  localparam int unsigned DIV_CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_CNT_W-1:0] DIV_TERM = DIV_CNT_W'(HALF - 1);
  localparam logic [15:0] LOCK_TERM = 16'(LOCK_CNT - 1);

  if ((DIV_RATIO < 2) || (DIV_RATIO > 256) || ((DIV_RATIO % 2) != 0)) begin : g_bad_div
    $error("refclk_gate_div: DIV_RATIO must be even and within 2..256");
  end
  if ((CE_SYNC_STAGES < 2) || (CE_SYNC_STAGES > 4)) begin : g_bad_sync
    $error("refclk_gate_div: CE_SYNC_STAGES must be within 2..4");
  end
  if ((LOCK_CNT < 1) || (LOCK_CNT > 65535)) begin : g_bad_lock
    $error("refclk_gate_div: LOCK_CNT must be within 1..65535");
  end

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_COUNT = 2'd1,
    LS_LOCK  = 2'd2
  } lock_state_e;

  logic [CE_SYNC_STAGES-1:0] ce_sync;
  logic                      ce_s;
  logic                      en_g;
  logic [DIV_CNT_W-1:0]      div_cnt;
  logic                      div_q;
  logic                      half_q;
  logic                      o_int;
  logic                      odiv_sel;
  lock_state_e               lock_state;
  logic [15:0]               lock_cnt;
  logic                      locked_q;
  logic                      unused_ib;

  assign unused_ib = IB;

  // Enable is carried in active-high form so the reset value means "gated off".
  always_ff @(posedge I or negedge RSTB) begin
    if (!RSTB) begin
      ce_sync <= '0;
    end else begin
      ce_sync <= {ce_sync[CE_SYNC_STAGES-2:0], ~CEB};
    end
  end

  assign ce_s = ce_sync[CE_SYNC_STAGES-1];

  // Updating only while I is low keeps every O high phase whole.
  always_ff @(negedge I or negedge RSTB) begin
    if (!RSTB) begin
      en_g <= 1'b0;
    end else begin
      en_g <= ce_s;
    end
  end

  assign o_int = I & en_g & ~REFCLK_EN_TX_PATH;
  assign O     = o_int;

  always_ff @(posedge I or negedge RSTB) begin
    if (!RSTB) begin
      div_cnt <= '0;
      div_q   <= 1'b0;
      half_q  <= 1'b0;
    end else if (!en_g) begin
      div_cnt <= '0;
      div_q   <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      half_q <= ~half_q;
      if (div_cnt == DIV_TERM) begin
        div_cnt <= '0;
        div_q   <= ~div_q;
      end else begin
        div_cnt <= div_cnt + DIV_CNT_W'(1);
      end
    end
  end

  always_comb begin
    odiv_sel = 1'b0;
    case (REFCLK_HROW_CK_SEL)
      2'b00:   odiv_sel = o_int;
      2'b01:   odiv_sel = half_q;
      2'b10:   odiv_sel = 1'b0;
      default: odiv_sel = div_q;
    endcase
  end

  assign ODIV2 = odiv_sel & ~REFCLK_EN_TX_PATH;

  // The edge that leaves IDLE is itself the first counted gated edge.
  always_ff @(posedge I or negedge RSTB) begin
    if (!RSTB) begin
      lock_state <= LS_IDLE;
      lock_cnt   <= '0;
      locked_q   <= 1'b0;
    end else begin
      case (lock_state)
        LS_IDLE: begin
          if (en_g) begin
            if (LOCK_CNT == 1) begin
              lock_state <= LS_LOCK;
              locked_q   <= ~REFCLK_EN_TX_PATH;
            end else begin
              lock_state <= LS_COUNT;
              lock_cnt   <= 16'd1;
            end
          end
        end
        LS_COUNT: begin
          if (!en_g) begin
            lock_state <= LS_IDLE;
            lock_cnt   <= '0;
          end else if (lock_cnt == LOCK_TERM) begin
            lock_state <= LS_LOCK;
            lock_cnt   <= '0;
            locked_q   <= ~REFCLK_EN_TX_PATH;
          end else begin
            lock_cnt <= lock_cnt + 16'd1;
          end
        end
        LS_LOCK: begin
          if (!en_g) begin
            lock_state <= LS_IDLE;
            locked_q   <= 1'b0;
          end
        end
        default: begin
          lock_state <= LS_IDLE;
          lock_cnt   <= '0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  assign LOCKED = locked_q;

endmodule

// File: tb/tb_refclk_gate_div.sv
// Self-checking bench for refclk_gate_div: five differently configured
// instances share one clock, reset and CEB, checked against an edge-history model.
module tb_refclk_gate_div;

  localparam int NI = 5;
  localparam int NS  [NI] = '{2, 3, 2, 4, 2};
  localparam int HS  [NI] = '{3, 2, 1, 4, 2};
  localparam int LKS [NI] = '{16, 3, 1, 5, 2};
  localparam int SEL [NI] = '{3, 1, 0, 2, 3};
  localparam int TXS [NI] = '{0, 0, 0, 0, 1};

  logic I, RSTB, IB, CEB;
  logic [NI-1:0] o_w, odiv_w, lk_w;

  int n_chk  = 0;
  int n_fail = 0;

  refclk_gate_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b11), .DIV_RATIO(6),
                    .CE_SYNC_STAGES(2), .LOCK_CNT(16)) u_d0 (
    .I(I), .RSTB(RSTB), .IB(IB), .CEB(CEB), .O(o_w[0]), .ODIV2(odiv_w[0]), .LOCKED(lk_w[0]));
  refclk_gate_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b01), .DIV_RATIO(4),
                    .CE_SYNC_STAGES(3), .LOCK_CNT(3)) u_d1 (
    .I(I), .RSTB(RSTB), .IB(IB), .CEB(CEB), .O(o_w[1]), .ODIV2(odiv_w[1]), .LOCKED(lk_w[1]));
  refclk_gate_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b00), .DIV_RATIO(2),
                    .CE_SYNC_STAGES(2), .LOCK_CNT(1)) u_d2 (
    .I(I), .RSTB(RSTB), .IB(IB), .CEB(CEB), .O(o_w[2]), .ODIV2(odiv_w[2]), .LOCKED(lk_w[2]));
  refclk_gate_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b10), .DIV_RATIO(8),
                    .CE_SYNC_STAGES(4), .LOCK_CNT(5)) u_d3 (
    .I(I), .RSTB(RSTB), .IB(IB), .CEB(CEB), .O(o_w[3]), .ODIV2(odiv_w[3]), .LOCKED(lk_w[3]));
  refclk_gate_div #(.REFCLK_EN_TX_PATH(1'b1), .REFCLK_HROW_CK_SEL(2'b11), .DIV_RATIO(4),
                    .CE_SYNC_STAGES(2), .LOCK_CNT(2)) u_d4 (
    .I(I), .RSTB(RSTB), .IB(IB), .CEB(CEB), .O(o_w[4]), .ODIV2(odiv_w[4]), .LOCKED(lk_w[4]));

  initial I = 1'b0;
  always #5 I = ~I;
  assign IB = ~I;

  // Model: enable seen at posedge k equals ~CEB sampled at posedge k-N since
  // reset release; outputs follow from the length of the current gated run.
  bit hist [8];
  int cyc = 0;
  int cur = -1;
  int run [NI];
  bit gat [NI];

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d t=%0t: got %b, expected %b", nm, idx, cur, $time, act, exp);
    end
  endtask

  task automatic check_all(input bit high);
    logic eo, eh, ed, ex, el;
    for (int i = 0; i < NI; i++) begin
      eo = RSTB && high && gat[i] && (TXS[i] == 0);
      eh = RSTB && gat[i] && (run[i] % 2 == 1);
      ed = RSTB && gat[i] && (((run[i] / HS[i]) % 2) == 1);
      case (SEL[i])
        0:       ex = eo;
        1:       ex = eh;
        2:       ex = 1'b0;
        default: ex = ed;
      endcase
      if (TXS[i] != 0) ex = 1'b0;
      el = RSTB && gat[i] && (run[i] >= LKS[i]) && (TXS[i] == 0);
      chk(high ? "O_hi" : "O_lo", i, o_w[i], eo);
      chk(high ? "ODIV2_hi" : "ODIV2_lo", i, odiv_w[i], ex);
      chk(high ? "LOCKED_hi" : "LOCKED_lo", i, lk_w[i], el);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      run[i] = 0;
      gat[i] = 1'b0;
    end
    forever begin
      @(posedge I);
      if (!RSTB) begin
        cyc = 0;
        cur = -1;
        for (int i = 0; i < NI; i++) begin
          run[i] = 0;
          gat[i] = 1'b0;
        end
      end else begin
        hist[cyc % 8] = !CEB;
        for (int i = 0; i < NI; i++) begin
          gat[i] = (cyc >= NS[i]) ? hist[(cyc - NS[i]) % 8] : 1'b0;
          run[i] = gat[i] ? run[i] + 1 : 0;
        end
        cur = cyc;
        cyc++;
      end
      #2 check_all(1'b1);
      @(negedge I);
      #2 check_all(1'b0);
    end
  end

  task automatic at_edge(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge I);
      #2;
      guard++;
    end while (cur != n && guard < 300);
    if (cur != n) begin
      n_chk++;
      n_fail++;
      $display("FAIL at_edge timeout: cycle %0d, expected %0d", cur, n);
    end
  endtask

  task automatic reset_pulse();
    RSTB = 1'b0;
    repeat (3) @(posedge I);
    @(negedge I);
    #3 RSTB = 1'b1;
  endtask

  initial begin
    int r, off1, off2;
    CEB  = 1'b0;
    RSTB = 1'b0;
    repeat (3) @(posedge I);
    @(negedge I);
    #3 RSTB = 1'b1;

    // Enable held through reset: first O pulse two edges after release.
    at_edge(0);  chk("lit_o_e0", 0, o_w[0], 1'b0);
    at_edge(1);  chk("lit_o_e1", 0, o_w[0], 1'b0);
    at_edge(2);  chk("lit_o_e2", 0, o_w[0], 1'b1); chk("lit_div_e2", 0, odiv_w[0], 1'b0);
    at_edge(3);  chk("lit_div_e3", 0, odiv_w[0], 1'b0);
    at_edge(4);  chk("lit_div_rise", 0, odiv_w[0], 1'b1);
    at_edge(6);  chk("lit_div_e6", 0, odiv_w[0], 1'b1);
    at_edge(7);  chk("lit_div_fall", 0, odiv_w[0], 1'b0);
    at_edge(16); chk("lit_lock_e16", 0, lk_w[0], 1'b0);
    at_edge(17); chk("lit_lock_e17", 0, lk_w[0], 1'b1);
    at_edge(20); #1 CEB = 1'b1;
    at_edge(22); chk("lit_last_o", 0, o_w[0], 1'b1); chk("lit_lock_hold", 0, lk_w[0], 1'b1);
    at_edge(23); chk("lit_o_off", 0, o_w[0], 1'b0); chk("lit_lock_fall", 0, lk_w[0], 1'b0);
    at_edge(25); #1 CEB = 1'b0;
    at_edge(29); chk("lit_re_div_e2", 0, odiv_w[0], 1'b0);
    at_edge(30); chk("lit_re_div_rise", 0, odiv_w[0], 1'b1);
    at_edge(33); chk("lit_re_div_fall", 0, odiv_w[0], 1'b0);

    // Reset mid-count with ten gated edges seen; outputs drop at once.
    at_edge(37);
    #1 RSTB = 1'b0;
    #1;
    chk("lit_rst_o", 0, o_w[0], 1'b0);
    chk("lit_rst_div", 0, odiv_w[0], 1'b0);
    chk("lit_rst_lock", 2, lk_w[2], 1'b0);
    chk("lit_rst_o2", 2, o_w[2], 1'b0);
    repeat (3) @(posedge I);
    @(negedge I);
    #3 RSTB = 1'b1;
    at_edge(16); chk("lit_relock_e16", 0, lk_w[0], 1'b0);
    at_edge(17); chk("lit_relock_e17", 0, lk_w[0], 1'b1);

    // Random asynchronous CEB edges and sub-period glitches.
    for (int c = 0; c < 1200; c++) begin
      @(posedge I);
      r = int'($urandom_range(0, 39));
      if (c == 600) begin
        #3 reset_pulse();
      end else if (r == 0) begin
        off1 = int'($urandom_range(1, 9));
        #(off1) CEB = ~CEB;
      end else if (r == 1) begin
        off1 = int'($urandom_range(1, 4));
        off2 = int'($urandom_range(off1 + 1, 9));
        #(off1) CEB = ~CEB;
        #(off2 - off1) CEB = ~CEB;
      end
    end

    repeat (4) @(posedge I);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
